// File: rtl/lisp_mem_pkg.sv
// Shared types for the heap access unit.
//   mem_op_t    : request opcode carried on req_op.
//   hau_state_t : sequencer state encoding.
//   CELL_WORDS  : words allocated per CONS cell.
package lisp_mem_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpCons  = 2'd2,
    OpRsvd  = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    StWaitBoot = 3'd0,
    StIdle     = 3'd1,
    StReadWait = 3'd2,
    StConsCdr  = 3'd3,
    StResp     = 3'd4,
    StFault    = 3'd5
  } hau_state_t;

  localparam int unsigned CELL_WORDS = 2;

endpackage

// File: rtl/heap_access_unit.sv
// Heap access unit: sole post-boot master of the memory controller RAM port.
// Sequences word READ/WRITE and two-word CONS requests, manages a bump-pointer
// heap and returns exactly one response per accepted request.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/op/addr   request handshake and command
//   req_data_a/b              WRITE data or CONS car / CONS cdr
//   resp_valid/ready          response handshake (held until accepted)
//   resp_data, resp_error     READ data / CONS pointer / WRITE address echo
//   heap_free_ptr             next free heap word address
//   fault                     sticky controller memory error seen
//   mem_*                     memory controller port (read data one cycle late)
module heap_access_unit
  import lisp_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned HEAP_BASE  = 16,
  parameter int unsigned HEAP_LIMIT = 2 ** ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data_a,
  input  logic [DATA_WIDTH-1:0] req_data_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH:0]   heap_free_ptr,
  output logic                  fault,
  input  logic                  mem_boot_done,
  input  logic                  mem_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // Pointer carries one extra bit so a completely full heap reads as 2**ADDR_WIDTH.
  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] HeapBase  = PtrW'(HEAP_BASE);
  localparam logic [PtrW-1:0] HeapLimit = PtrW'(HEAP_LIMIT);

  hau_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_error_q, resp_error_d;
  logic [PtrW-1:0]       heap_ptr_q, heap_ptr_d;
  logic [DATA_WIDTH-1:0] cdr_q, cdr_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cons_fits;

  // Both cell words must sit at or below the limit; no wrap at PtrW bits.
  assign cons_fits = (heap_ptr_q + PtrW'(1)) <= HeapLimit;

  always_comb begin
    state_d          = state_q;
    resp_data_d      = resp_data_q;
    resp_error_d     = resp_error_q;
    heap_ptr_d       = heap_ptr_q;
    cdr_d            = cdr_q;
    fault_d          = fault_q;
    req_ready        = 1'b0;
    mem_write_enable = 1'b0;
    // Memory address/data hold their last driven value when idle.
    mem_addr         = mem_addr_q;
    mem_write_data   = mem_wdata_q;

    if (rst) begin
      // Nothing is issued during the reset cycle, in particular no cdr write.
    end else if (mem_error) begin
      // Fault wins over any request or in-flight step; pending response dropped.
      state_d = StFault;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        StWaitBoot: begin
          if (mem_boot_done) state_d = StIdle;
        end
        StIdle: begin
          req_ready = 1'b1;
          if (req_valid) begin
            unique case (req_op)
              OpRead: begin
                mem_addr = req_addr;
                state_d  = StReadWait;
              end
              OpWrite: begin
                mem_write_enable = 1'b1;
                mem_addr         = req_addr;
                mem_write_data   = req_data_a;
                resp_data_d      = DATA_WIDTH'(req_addr);
                resp_error_d     = 1'b0;
                state_d          = StResp;
              end
              OpCons: begin
                if (cons_fits) begin
                  // Car goes out now; the pointer is left unchanged until the
                  // cdr cycle so it doubles as the latched cell address.
                  mem_write_enable = 1'b1;
                  mem_addr         = heap_ptr_q[ADDR_WIDTH-1:0];
                  mem_write_data   = req_data_a;
                  cdr_d            = req_data_b;
                  state_d          = StConsCdr;
                end else begin
                  resp_data_d  = '0;
                  resp_error_d = 1'b1;
                  state_d      = StResp;
                end
              end
              default: begin
                resp_data_d  = '0;
                resp_error_d = 1'b1;
                state_d      = StResp;
              end
            endcase
          end
        end
        StReadWait: begin
          resp_data_d  = mem_read_data;
          resp_error_d = 1'b0;
          state_d      = StResp;
        end
        StConsCdr: begin
          mem_write_enable = 1'b1;
          mem_addr         = heap_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
          mem_write_data   = cdr_q;
          heap_ptr_d       = heap_ptr_q + PtrW'(CELL_WORDS);
          resp_data_d      = DATA_WIDTH'(heap_ptr_q[ADDR_WIDTH-1:0]);
          resp_error_d     = 1'b0;
          state_d          = StResp;
        end
        StResp: begin
          if (resp_ready) state_d = StIdle;
        end
        StFault: begin
          // Left only by reset.
        end
        default: begin
          state_d = StFault;
          fault_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitBoot;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      heap_ptr_q   <= HeapBase;
      cdr_q        <= '0;
      fault_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      heap_ptr_q   <= heap_ptr_d;
      cdr_q        <= cdr_d;
      fault_q      <= fault_d;
      mem_addr_q   <= mem_addr;
      mem_wdata_q  <= mem_write_data;
    end
  end

  assign resp_valid    = (state_q == StResp);
  assign resp_data     = resp_data_q;
  assign resp_error    = resp_error_q;
  assign heap_free_ptr = heap_ptr_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_heap_access_unit.sv
// Self-checking bench for heap_access_unit. Instance A uses the default heap
// (base 0x10) with a RAM model; instance B uses a four-word heap (0xFC..0xFF).
module tb_heap_access_unit;
  import lisp_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, boot;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Instance A signals
  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_error;
  logic [1:0]  a_req_op;
  logic [7:0]  a_req_addr, a_maddr;
  logic [15:0] a_da, a_db, a_resp_data, a_wd, a_rd;
  logic [8:0]  a_ptr;
  logic        a_fault, a_mem_error, a_we;
  // Instance B signals
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_error;
  logic [1:0]  b_req_op;
  logic [7:0]  b_req_addr, b_maddr;
  logic [15:0] b_da, b_db, b_resp_data, b_wd, b_rd;
  logic [8:0]  b_ptr;
  logic        b_fault, b_mem_error, b_we;
  assign b_rd = '0;

  heap_access_unit u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_data_a(a_da), .req_data_b(a_db), .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready), .resp_data(a_resp_data), .resp_error(a_resp_error),
    .heap_free_ptr(a_ptr), .fault(a_fault), .mem_boot_done(boot), .mem_error(a_mem_error),
    .mem_write_enable(a_we), .mem_addr(a_maddr), .mem_write_data(a_wd), .mem_read_data(a_rd)
  );

  heap_access_unit #(.HEAP_BASE(252), .HEAP_LIMIT(255)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_data_a(b_da), .req_data_b(b_db), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_error(b_resp_error),
    .heap_free_ptr(b_ptr), .fault(b_fault), .mem_boot_done(boot), .mem_error(b_mem_error),
    .mem_write_enable(b_we), .mem_addr(b_maddr), .mem_write_data(b_wd), .mem_read_data(b_rd)
  );

  // RAM model for A (one-cycle read latency) plus write monitors.
  logic [15:0] ram [256] = '{default: '0};
  logic [7:0]  wlog_addr [$];
  logic [15:0] wlog_data [$];
  int          wlog_cyc  [$];
  int          b_wcount = 0;

  always @(posedge clk) begin
    if (a_we) begin
      ram[a_maddr] <= a_wd;
      wlog_addr.push_back(a_maddr);
      wlog_data.push_back(a_wd);
      wlog_cyc.push_back(cyc);
    end
    a_rd <= ram[a_maddr];
    if (b_we) b_wcount <= b_wcount + 1;
    cyc <= cyc + 1;
  end

  // Reference model for A: flat word memory plus bump pointer.
  logic [15:0] ref_mem [256] = '{default: '0};
  int          ref_ptr = 16;
  logic [15:0] exp_d;
  logic        exp_e;

  task automatic ref_step(input logic [1:0] op, input logic [7:0] addr,
                          input logic [15:0] a, input logic [15:0] b);
    exp_d = '0;
    exp_e = 1'b0;
    case (op)
      2'd0: exp_d = ref_mem[addr];
      2'd1: begin
        ref_mem[addr] = a;
        exp_d = {8'h00, addr};
      end
      2'd2: begin
        if (ref_ptr + 1 <= 255) begin
          ref_mem[ref_ptr]     = a;
          ref_mem[ref_ptr + 1] = b;
          exp_d = 16'(ref_ptr);
          ref_ptr += 2;
        end else begin
          exp_e = 1'b1;
        end
      end
      default: exp_e = 1'b1;
    endcase
  endtask

  // Issue one request and wait for its response (not released).
  task automatic issue(input bit sel, input logic [1:0] op, input logic [7:0] addr,
                       input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] d, output logic e, output int lat);
    int w = 0;
    @(negedge clk);
    while (!(sel ? b_req_ready : a_req_ready) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready still 0 after %0d cycles, required 1", w);
    end
    if (!sel) ref_step(op, addr, a, b);
    if (sel) begin
      b_req_valid = 1'b1; b_req_op = op; b_req_addr = addr; b_da = a; b_db = b;
    end else begin
      a_req_valid = 1'b1; a_req_op = op; a_req_addr = addr; a_da = a; a_db = b;
    end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 1;
    while (!(sel ? b_resp_valid : a_resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: resp_valid still 0 after %0d cycles, required 1", lat);
    end
    d = sel ? b_resp_data : a_resp_data;
    e = sel ? b_resp_error : a_resp_error;
  endtask

  task automatic release_resp();
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; boot = 1'b0;
    a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_da = 0; a_db = 0; a_resp_ready = 0;
    b_req_valid = 0; b_req_op = 0; b_req_addr = 0; b_da = 0; b_db = 0; b_resp_ready = 0;
    a_mem_error = 0; b_mem_error = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_req_ready, a_resp_valid, a_resp_error, a_fault, a_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {a_req_ready, a_resp_valid, a_resp_error, a_fault, a_we});
    end
    checks++;
    if (a_resp_data !== 16'h0 || a_maddr !== 8'h0 || a_wd !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: resp_data=%h mem_addr=%h wdata=%h, required all 0",
               a_resp_data, a_maddr, a_wd);
    end
    checks++;
    if (a_ptr !== 9'h010) begin
      errors++;
      $display("FAIL reset_ptr_a: got %h, required 010", a_ptr);
    end
    checks++;
    if (b_ptr !== 9'h0FC) begin
      errors++;
      $display("FAIL reset_ptr_b: got %h, required 0fc", b_ptr);
    end
  endtask

  task automatic test_boot_gating();
    int bad = 0;
    @(negedge clk);
    rst = 1'b0;
    a_req_valid = 1'b1; a_req_op = 2'd1; a_req_addr = 8'h05; a_da = 16'hDEAD;
    repeat (10) begin
      @(negedge clk);
      if (a_req_ready !== 1'b0 || a_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL boot_gating: %0d cycles with ready/write set, required 0", bad);
    end
    boot = 1'b1;
    a_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL boot_ready: a=%b b=%b, required 1 1", a_req_ready, b_req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] d;
    logic        e;
    int          lat;
    issue(0, 2'd1, 8'h05, 16'hBEEF, 16'h0, d, e, lat);
    checks++;
    if (d !== 16'h0005 || e !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL write_resp: data=%h err=%b lat=%0d, required 0005 0 1", d, e, lat);
    end
    release_resp();
    issue(0, 2'd0, 8'h05, 16'h0, 16'h0, d, e, lat);
    checks++;
    if (d !== 16'hBEEF || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL read_resp: data=%h err=%b lat=%0d, required beef 0 2", d, e, lat);
    end
    release_resp();
  endtask

  task automatic test_cons();
    logic [15:0] d;
    logic        e;
    int          lat;
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    issue(0, 2'd2, 8'h00, 16'h0011, 16'h0022, d, e, lat);
    checks++;
    if (d !== 16'h0010 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL cons_resp: data=%h err=%b lat=%0d, required 0010 0 2", d, e, lat);
    end
    checks++;
    if (wlog_addr.size() != 2) begin
      errors++;
      $display("FAIL cons_writes: got %0d writes, required 2", wlog_addr.size());
    end else if (wlog_addr[0] !== 8'h10 || wlog_data[0] !== 16'h0011 ||
                 wlog_addr[1] !== 8'h11 || wlog_data[1] !== 16'h0022 ||
                 wlog_cyc[1] != wlog_cyc[0] + 1) begin
      errors++;
      $display("FAIL cons_writes: %h<=%h @%0d, %h<=%h @%0d, required 10<=0011, 11<=0022 consecutive",
               wlog_addr[0], wlog_data[0], wlog_cyc[0], wlog_addr[1], wlog_data[1], wlog_cyc[1]);
    end
    release_resp();
    checks++;
    if (a_ptr !== 9'h012) begin
      errors++;
      $display("FAIL cons_ptr: got %h, required 012", a_ptr);
    end
    issue(0, 2'd0, 8'h10, 16'h0, 16'h0, d, e, lat);
    checks++;
    if (d !== 16'h0011) begin
      errors++;
      $display("FAIL cons_car: got %h, required 0011", d);
    end
    release_resp();
    issue(0, 2'd0, 8'h11, 16'h0, 16'h0, d, e, lat);
    checks++;
    if (d !== 16'h0022) begin
      errors++;
      $display("FAIL cons_cdr: got %h, required 0022", d);
    end
    release_resp();
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic        e;
    int          lat;
    int          bad = 0;
    issue(0, 2'd0, 8'h05, 16'h0, 16'h0, d, e, lat);
    checks++;
    if (d !== 16'hBEEF) begin
      errors++;
      $display("FAIL bp_data: got %h, required beef", d);
    end
    repeat (5) begin
      @(negedge clk);
      if (a_resp_valid !== 1'b1 || a_resp_data !== 16'hBEEF || a_req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    release_resp();
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b, required 1 0", a_req_ready, a_resp_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic        e;
    int          lat, exp_lat, bad;
    logic [1:0]  op;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(0, op, 8'($urandom_range(0, 63)), 16'($urandom), 16'($urandom), d, e, lat);
      exp_lat = (op == 2'd0 || (op == 2'd2 && !exp_e)) ? 2 : 1;
      checks++;
      if (d !== exp_d || e !== exp_e || lat != exp_lat) begin
        errors++;
        $display("FAIL random_resp[%0d] op=%0d: data=%h err=%b lat=%0d, required %h %b %0d",
                 i, op, d, e, lat, exp_d, exp_e, exp_lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_resp();
      if (a_ptr !== 9'(ref_ptr)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_ptr: %0d pointer mismatches, final %h required %h", bad, a_ptr,
               ref_ptr);
    end
  endtask

  task automatic test_exhaustion();
    logic [15:0] d;
    logic        e;
    int          lat, w0;
    issue(1, 2'd2, 8'h00, 16'h00A1, 16'h00B1, d, e, lat);
    checks++;
    if (d !== 16'h00FC || e !== 1'b0) begin
      errors++;
      $display("FAIL exh_cons1: data=%h err=%b, required 00fc 0", d, e);
    end
    release_resp();
    issue(1, 2'd2, 8'h00, 16'h00A2, 16'h00B2, d, e, lat);
    checks++;
    if (d !== 16'h00FE || e !== 1'b0) begin
      errors++;
      $display("FAIL exh_cons2: data=%h err=%b, required 00fe 0", d, e);
    end
    release_resp();
    w0 = b_wcount;
    issue(1, 2'd2, 8'h00, 16'h00A3, 16'h00B3, d, e, lat);
    checks++;
    if (d !== 16'h0000 || e !== 1'b1 || b_wcount != w0) begin
      errors++;
      $display("FAIL exh_cons3: data=%h err=%b writes=%0d, required 0000 1 0", d, e,
               b_wcount - w0);
    end
    release_resp();
    checks++;
    if (b_ptr !== 9'h100 || b_wcount != 4) begin
      errors++;
      $display("FAIL exh_ptr: ptr=%h writes=%0d, required 100 4", b_ptr, b_wcount);
    end
  endtask

  task automatic test_fault();
    int bad = 0;
    int w = 0;
    logic [8:0] ptr_before;
    @(negedge clk);
    while (!a_req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ptr_before = a_ptr;
    a_req_valid = 1'b1; a_req_op = 2'd2; a_da = 16'h1234; a_db = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_mem_error = 1'b1;
    #1;
    checks++;
    if (a_we !== 1'b0) begin
      errors++;
      $display("FAIL fault_cdr_write: we=%b, required 0", a_we);
    end
    @(negedge clk);
    a_mem_error = 1'b0;
    a_req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (a_fault !== 1'b1 || a_resp_valid !== 1'b0 || a_req_ready !== 1'b0 || a_we !== 1'b0)
        bad++;
    end
    a_req_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fault_hold: %0d bad cycles, required 0", bad);
    end
    checks++;
    if (a_ptr !== ptr_before) begin
      errors++;
      $display("FAIL fault_ptr: got %h, required %h", a_ptr, ptr_before);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ptr !== 9'h010 || a_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: ptr=%h fault=%b, required 010 0", a_ptr, a_fault);
    end
  endtask

  initial begin
    test_reset();
    test_boot_gating();
    test_write_read();
    test_cons();
    test_backpressure();
    test_random();
    test_exhaustion();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
